// File: rtl/matrix_mac_engine.sv
// N x N matrix multiply-accumulate engine: C = A x B with one multiply per cycle.
// Each result element is reduced to ACC_W bits, and ovf is a sticky per-job overflow flag.
module matrix_mac_engine #(
    parameter int N        = 3,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N*N*DATA_W-1:0]    a_flat,
    input  logic [N*N*DATA_W-1:0]    b_flat,
    output logic [N*N*ACC_W-1:0]     c_flat,
    output logic                     busy,
    output logic                     done,
    output logic                     c_valid,
    output logic                     ovf
);

    localparam int CNT_W = $clog2(N);
    localparam int IDX_W = $clog2(N * N);
    localparam int SUM_W = 2 * DATA_W + $clog2(N);
    localparam int EXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Clamp limits of the ACC_W result range, held one bit wider than either operand so comparisons are exact.
    localparam logic signed [EXT_W-1:0] MAX_V = (SIGNED != 0)
        ? signed'((EXT_W'(1) << (ACC_W - 1)) - EXT_W'(1))
        : signed'((EXT_W'(1) << ACC_W) - EXT_W'(1));
    localparam logic signed [EXT_W-1:0] MIN_V = (SIGNED != 0)
        ? signed'(-(EXT_W'(1) << (ACC_W - 1)))
        : '0;

    logic [1:0]              state_q, state_d;
    logic [N*N*DATA_W-1:0]   a_q, b_q;
    logic [CNT_W-1:0]        i_q, j_q, k_q;
    logic [SUM_W-1:0]        p_q, acc_q;
    logic                    p_valid_q, p_first_q, p_last_q;
    logic [IDX_W-1:0]        p_idx_q;
    logic [N*N*ACC_W-1:0]    c_q;
    logic                    done_q, c_valid_q, ovf_q;

    logic                    accept, last_i, last_j, last_k, last_issue;
    logic [DATA_W-1:0]       a_el, b_el;
    logic [SUM_W-1:0]        a_ext, b_ext, prod_d, sum_d;
    logic signed [EXT_W-1:0] sum_ext;
    logic                    over_hi, over_lo;
    logic [ACC_W-1:0]        red_d;

    assign accept     = (state_q == S_IDLE) && start;
    assign last_i     = (i_q == CNT_W'(N - 1));
    assign last_j     = (j_q == CNT_W'(N - 1));
    assign last_k     = (k_q == CNT_W'(N - 1));
    assign last_issue = last_i && last_j && last_k;

    // NOTE: every combinational output gets a default before any branch, so no path can leave a latch behind.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_issue) state_d = S_DRAIN;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 1 operands: extend to the accumulator width so the truncated product is exact in both modes.
    always_comb begin
        a_el = a_q[(int'(i_q) * N + int'(k_q)) * DATA_W +: DATA_W];
        b_el = b_q[(int'(k_q) * N + int'(j_q)) * DATA_W +: DATA_W];
        if (SIGNED != 0) begin
            a_ext = SUM_W'(signed'(a_el));
            b_ext = SUM_W'(signed'(b_el));
        end else begin
            a_ext = SUM_W'(a_el);
            b_ext = SUM_W'(b_el);
        end
        prod_d = a_ext * b_ext;
    end

    always_comb begin
        sum_d = p_first_q ? p_q : acc_q + p_q;
        if (SIGNED != 0) sum_ext = EXT_W'(signed'(sum_d));
        else             sum_ext = signed'(EXT_W'(sum_d));
        over_hi = sum_ext > MAX_V;
        over_lo = sum_ext < MIN_V;
        red_d   = sum_ext[ACC_W-1:0];
        if (SATURATE != 0 && over_hi) red_d = MAX_V[ACC_W-1:0];
        if (SATURATE != 0 && over_lo) red_d = MIN_V[ACC_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_idx_q   <= '0;
            // NOTE: the result store is a visible output rather than a hidden RAM, so reset clears it too.
            c_q       <= '0;
            done_q    <= 1'b0;
            c_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= (state_q == S_DRAIN);
            p_valid_q <= (state_q == S_RUN);

            if (accept) begin
                a_q       <= a_flat;
                b_q       <= b_flat;
                i_q       <= '0;
                j_q       <= '0;
                k_q       <= '0;
                ovf_q     <= 1'b0;
                c_valid_q <= 1'b0;
            end else if (state_q == S_DRAIN) begin
                c_valid_q <= 1'b1;
            end

            if (state_q == S_RUN) begin
                p_q       <= prod_d;
                p_first_q <= (k_q == '0);
                p_last_q  <= last_k;
                p_idx_q   <= IDX_W'(int'(i_q) * N + int'(j_q));
                if (last_k) begin
                    k_q <= '0;
                    if (last_j) begin
                        j_q <= '0;
                        i_q <= last_i ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end

            if (p_valid_q) begin
                acc_q <= sum_d;
                if (p_last_q) begin
                    c_q[int'(p_idx_q) * ACC_W +: ACC_W] <= red_d;
                    if (over_hi || over_lo) ovf_q <= 1'b1;
                end
            end
        end
    end

    assign c_flat  = c_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign c_valid = c_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: four parameterisations, a vector table fed through a scoreboard,
// and hand-written sequences for back-to-back start and mid-job reset.
module tb_matrix_mac_engine;

    typedef struct {
        int           inst;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] c;
        logic         ovf;
        int           lat;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   start_v;
    logic [255:0] a_in [4];
    logic [255:0] b_in [4];
    logic [143:0] c0, c1, c2;
    logic [255:0] c3;
    logic         busy0, busy1, busy2, busy3;
    logic         done0, done1, done2, done3;
    logic         cv0, cv1, cv2, cv3;
    logic         ovf0, ovf1, ovf2, ovf3;
    logic [3:0]   busy_v, done_v, cv_v, ovf_v;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t sb [$];
    vec_t tbl [$];

    always #5 clk = ~clk;

    assign busy_v = {busy3, busy2, busy1, busy0};
    assign done_v = {done3, done2, done1, done0};
    assign cv_v   = {cv3, cv2, cv1, cv0};
    assign ovf_v  = {ovf3, ovf2, ovf1, ovf0};

    matrix_mac_engine u_def (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .a_flat(a_in[0][71:0]), .b_flat(b_in[0][71:0]), .c_flat(c0),
        .busy(busy0), .done(done0), .c_valid(cv0), .ovf(ovf0));

    matrix_mac_engine #(.SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .a_flat(a_in[1][71:0]), .b_flat(b_in[1][71:0]), .c_flat(c1),
        .busy(busy1), .done(done1), .c_valid(cv1), .ovf(ovf1));

    matrix_mac_engine #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .a_flat(a_in[2][71:0]), .b_flat(b_in[2][71:0]), .c_flat(c2),
        .busy(busy2), .done(done2), .c_valid(cv2), .ovf(ovf2));

    matrix_mac_engine #(.N(4), .DATA_W(4)) u_n4 (
        .clk(clk), .rst(rst), .start(start_v[3]),
        .a_flat(a_in[3][63:0]), .b_flat(b_in[3][63:0]), .c_flat(c3),
        .busy(busy3), .done(done3), .c_valid(cv3), .ovf(ovf3));

    function automatic logic [255:0] c_of(input int inst);
        case (inst)
            0:       return 256'(c0);
            1:       return 256'(c1);
            2:       return 256'(c2);
            default: return c3;
        endcase
    endfunction

    function automatic logic [255:0] splat(input int n_el, input int w, input longint val);
        logic [255:0] r = '0;
        for (int e = 0; e < n_el; e++)
            r |= (256'(val) & ((256'(1) << w) - 1)) << (e * w);
        return r;
    endfunction

    function automatic longint get_el(input logic [255:0] m, input int pos, input int w, input int sgn);
        longint v = longint'((m >> pos) & ((256'(1) << w) - 1));
        if (sgn != 0 && v >= (longint'(1) << (w - 1))) v -= (longint'(1) << w);
        return v;
    endfunction

    // Reference: plain integer matrix product, then range check and clamp or truncate.
    function automatic void model(input int n, input int dw, input int accw, input int sgn, input int sat,
                                  input logic [255:0] a, input logic [255:0] b,
                                  output logic [255:0] c, output logic o);
        longint s, hi, lo, r;
        c  = '0;
        o  = 1'b0;
        hi = (sgn != 0) ? (longint'(1) << (accw - 1)) - 1 : (longint'(1) << accw) - 1;
        lo = (sgn != 0) ? -(longint'(1) << (accw - 1)) : 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += get_el(a, (i * n + k) * dw, dw, sgn) * get_el(b, (k * n + j) * dw, dw, sgn);
                r = s;
                if (s > hi) begin o = 1'b1; if (sat != 0) r = hi; end
                if (s < lo) begin o = 1'b1; if (sat != 0) r = lo; end
                c |= (256'(r) & ((256'(1) << accw) - 1)) << ((i * n + j) * accw);
            end
        end
    endfunction

    function automatic vec_t mk(input int inst, input logic [255:0] a, input logic [255:0] b,
                                input logic [255:0] c, input logic o, input int lat, input string name);
        vec_t v;
        v.inst = inst; v.a = a; v.b = b; v.c = c; v.ovf = o; v.lat = lat; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int inst, input int init, output int cyc);
        cyc = init;
        while (done_v[inst] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic compare_out(input int inst, input int cyc);
        vec_t e;
        check("scoreboard has entry", 256'(sb.size() != 0), 256'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({e.name, " latency"}, 256'(cyc), 256'(e.lat));
        check({e.name, " c_flat"}, c_of(inst), e.c);
        check({e.name, " ovf"}, 256'(ovf_v[inst]), 256'(e.ovf));
        check({e.name, " c_valid"}, 256'(cv_v[inst]), 256'(1));
        check({e.name, " busy low"}, 256'(busy_v[inst]), 256'(0));
        @(negedge clk);
        check({e.name, " done one cycle"}, 256'(done_v[inst]), 256'(0));
    endtask

    task automatic run_job(input vec_t v);
        int cyc;
        sb.push_back(v);
        @(negedge clk);
        a_in[v.inst]    = v.a;
        b_in[v.inst]    = v.b;
        start_v[v.inst] = 1'b1;
        @(negedge clk);
        start_v[v.inst] = 1'b0;
        check({v.name, " busy after start"}, 256'(busy_v[v.inst]), 256'(1));
        check({v.name, " c_valid cleared"}, 256'(cv_v[v.inst]), 256'(0));
        check({v.name, " ovf cleared"}, 256'(ovf_v[v.inst]), 256'(0));
        wait_done(v.inst, 0, cyc);
        compare_out(v.inst, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] basic_a, basic_b, basic_c, ff8, id4, seq4, ra, rb, mc;
        logic         mo;
        int           exp_basic [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        int           cyc;
        int           dcount;

        basic_a = '0; basic_b = '0; basic_c = '0; id4 = '0; seq4 = '0;
        for (int e = 0; e < 9; e++) begin
            basic_a[e * 8 +: 8]  = 8'(e + 1);
            basic_b[e * 8 +: 8]  = 8'(9 - e);
            basic_c[e * 16 +: 16] = 16'(exp_basic[e]);
        end
        for (int e = 0; e < 16; e++) begin
            id4[e * 4 +: 4]  = ((e / 4) == (e % 4)) ? 4'd1 : 4'd0;
            seq4[e * 4 +: 4] = 4'(e);
        end
        ff8 = splat(9, 8, 255);

        tbl.push_back(mk(0, basic_a, basic_b, basic_c, 1'b0, 28, "basic"));
        tbl.push_back(mk(0, ff8, ff8, splat(9, 16, 65535), 1'b1, 28, "sat all ff"));
        for (int t = 0; t < 2; t++) begin
            ra = '0; rb = '0;
            for (int e = 0; e < 9; e++) begin
                ra[e * 8 +: 8] = 8'($urandom_range(0, 100));
                rb[e * 8 +: 8] = 8'($urandom_range(0, 100));
            end
            model(3, 8, 16, 0, 1, ra, rb, mc, mo);
            tbl.push_back(mk(0, ra, rb, mc, mo, 28, $sformatf("rand unsigned %0d", t)));
        end
        tbl.push_back(mk(1, ff8, ff8, splat(9, 16, 64003), 1'b1, 28, "wrap all ff"));
        tbl.push_back(mk(2, splat(9, 8, 'h80), splat(9, 8, 'hff), splat(9, 16, 384), 1'b0, 28, "signed 80 x ff"));
        tbl.push_back(mk(2, splat(9, 8, 'h80), splat(9, 8, 'h80), splat(9, 16, 32767), 1'b1, 28, "signed 80 x 80"));
        ra = '0; rb = '0;
        for (int e = 0; e < 9; e++) begin
            ra[e * 8 +: 8] = 8'($urandom);
            rb[e * 8 +: 8] = 8'($urandom);
        end
        model(3, 8, 16, 1, 1, ra, rb, mc, mo);
        tbl.push_back(mk(2, ra, rb, mc, mo, 28, "rand signed"));
        tbl.push_back(mk(3, id4, seq4, splat(16, 16, 0) | seq4_to_c(seq4), 1'b0, 65, "n4 identity"));

        rst     = 1'b0;
        start_v = '0;
        for (int n = 0; n < 4; n++) begin
            a_in[n] = '0;
            b_in[n] = '0;
        end
        #1;
        check("reset busy", 256'(busy_v), 256'(0));
        check("reset done", 256'(done_v), 256'(0));
        check("reset c_valid", 256'(cv_v), 256'(0));
        check("reset ovf", 256'(ovf_v), 256'(0));
        for (int n = 0; n < 4; n++) check($sformatf("reset c_flat %0d", n), c_of(n), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < tbl.size(); t++) run_job(tbl[t]);

        // start held high through a job whose inputs change mid-run; second job begins on the done cycle
        sb.push_back(mk(0, basic_a, basic_b, basic_c, 1'b0, 28, "held job1"));
        sb.push_back(mk(0, ff8, ff8, splat(9, 16, 65535), 1'b1, 28, "held job2"));
        @(negedge clk);
        a_in[0] = basic_a; b_in[0] = basic_b; start_v[0] = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        a_in[0] = ff8; b_in[0] = ff8;
        wait_done(0, 5, cyc);
        compare_out(0, cyc);
        check("held job2 accepted without gap", 256'(busy_v[0]), 256'(1));
        start_v[0] = 1'b0;
        wait_done(0, 0, cyc);
        compare_out(0, cyc);

        // reset at cycle 10 of a job aborts it without a done pulse
        @(negedge clk);
        a_in[0] = basic_a; b_in[0] = basic_b; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy before reset", 256'(busy_v[0]), 256'(1));
        rst = 1'b0;
        #1;
        check("abort busy", 256'(busy_v[0]), 256'(0));
        check("abort done", 256'(done_v[0]), 256'(0));
        check("abort c_valid", 256'(cv_v[0]), 256'(0));
        check("abort ovf", 256'(ovf_v[0]), 256'(0));
        check("abort c_flat", c_of(0), 256'(0));
        dcount = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 2) rst = 1'b1;
            if (done_v[0] === 1'b1) dcount++;
        end
        check("abort no done pulse", 256'(dcount), 256'(0));
        run_job(mk(0, basic_a, basic_b, basic_c, 1'b0, 28, "after abort"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Expected N=4 result when A is the identity: each 4-bit B element widened to a 16-bit C element.
    function automatic logic [255:0] seq4_to_c(input logic [255:0] b);
        logic [255:0] r = '0;
        for (int e = 0; e < 16; e++) r |= ((b >> (e * 4)) & 256'hf) << (e * 16);
        return r;
    endfunction

endmodule
